// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers beside the EX-stage ALU.
// One op runs WIDTH shift-add / restoring-divide steps, then a sign-fix edge writes HI/LO.
module muldiv_sequencer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] DIV0_QUOT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;
  logic [WIDTH-1:0]   opa;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   abs1, abs2;
  logic               op_signed;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_r, div_d;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    op_signed = ~op[0];
    abs1 = (op_signed && In1[WIDTH-1]) ? -In1 : In1;
    abs2 = (op_signed && In2[WIDTH-1]) ? -In2 : In2;

    // Multiplier sits in the low half and shifts out as the product shifts in.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Remainder in the high half, dividend/quotient in the low half.
    div_r    = acc[2*WIDTH-1:WIDTH-1];
    div_d    = div_r - {1'b0, opa};
    div_ge   = (div_r >= {1'b0, opa});
    div_next = {(div_ge ? div_d[WIDTH-1:0] : div_r[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    prod_fix = neg_q ? -acc : acc;
    quot_fix = div0 ? DIV0_QUOT : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  assign busy  = (state != IDLE);
  assign stall = (start | hilo_read) & busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opa    <= '0;
      acc    <= '0;
      HI     <= '0;
      LO     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) HI <= wdata;
          if (lo_we) LO <= wdata;
          if (start) begin
            state  <= RUN;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= op_signed & (In1[WIDTH-1] ^ In2[WIDTH-1]);
            neg_r  <= op_signed & In1[WIDTH-1];
            div0   <= op[1] & (In2 == '0);
            if (op[1]) begin
              opa <= abs2;
              acc <= {{WIDTH{1'b0}}, abs1};
            end else begin
              opa <= abs1;
              acc <= {{WIDTH{1'b0}}, abs2};
            end
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            HI <= rem_fix;
            LO <= quot_fix;
          end else begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner ops, random ops against a
// 64-bit arithmetic reference, stall/mthi/mtlo interaction and mid-op reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] In1, In2;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        hilo_read;
  logic [31:0] HI, LO;
  logic        busy, done, stall;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .In1(In1), .In2(In2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hilo_read(hilo_read),
    .HI(HI), .LO(LO), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and
  // the remainder takes the dividend's sign, matching the MIPS-style results.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      2'd2: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
  endtask

  // Issues one op (assumes the unit is idle), optionally with a same-cycle mthi.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit with_mthi);
    logic [31:0] ehi, elo, mval;
    int lat;
    ref_model(o, a, b, ehi, elo);
    mval  = $urandom;
    start = 1'b1; op = o; In1 = a; In2 = b;
    hi_we = with_mthi; wdata = mval;
    step();
    start = 1'b0; hi_we = 1'b0;
    check({tag, ".busy_after_start"}, 64'(busy), 64'd1);
    check({tag, ".done_cleared"}, 64'(done), 64'd0);
    if (with_mthi) check({tag, ".mthi_with_start"}, 64'(HI), 64'(mval));
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      In1 = $urandom; In2 = $urandom; op = 2'($urandom_range(0, 3));
      step();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'd33);
    check({tag, ".HI"}, 64'(HI), 64'(ehi));
    check({tag, ".LO"}, 64'(LO), 64'(elo));
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  o;
    int n, seen_done;

    reset = 1'b1; start = 1'b0; op = 2'd0; In1 = '0; In2 = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; hilo_read = 1'b0;
    step(); step();
    reset = 1'b0;
    hilo_read = 1'b1;
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.HI", 64'(HI), 64'd0);
    check("reset.LO", 64'(LO), 64'd0);
    check("reset.stall_idle", 64'(stall), 64'd0);
    hilo_read = 1'b0;

    run_op("mult_7x6", 2'd0, 32'd7, 32'd6, 1'b0);
    check("mult_7x6.busy_at_done", 64'(busy), 64'd0);
    run_op("mult_m1x1", 2'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max.HI_const", 64'(HI), 64'hFFFF_FFFE);
    check("multu_max.LO_const", 64'(LO), 64'h0000_0001);
    run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2.LO_const", 64'(LO), 64'hFFFF_FFFD);
    check("div_m7_2.HI_const", 64'(HI), 64'hFFFF_FFFF);
    run_op("divu_7_2", 2'd3, 32'd7, 32'd2, 1'b0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf.LO_const", 64'(LO), 64'h8000_0000);
    run_op("divu_5_0", 2'd3, 32'd5, 32'd0, 1'b0);
    check("divu_5_0.LO_const", 64'(LO), 64'hFFFF_FFFF);
    check("divu_5_0.HI_const", 64'(HI), 64'd5);
    run_op("div_neg_0", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("mult_minneg", 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), o, a, b, ($urandom_range(0, 3) == 0));
    end
    step();
    check("done_one_cycle", 64'(done), 64'd0);

    // Stall / ignored second start / ignored mtlo while busy.
    start = 1'b1; op = 2'd0; In1 = 32'd3; In2 = 32'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    start = 1'b1; op = 2'd3; In1 = 32'd100; In2 = 32'd7;
    hilo_read = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      check("stall_while_busy", 64'(stall), 64'd1);
      step();
      n++;
    end
    check("stall.released_in_bound", 64'(n < 40), 64'd1);
    check("stall.idle", 64'(stall), 64'd0);
    start = 1'b0; lo_we = 1'b0; hilo_read = 1'b0;
    #1;
    check("stall.done", 64'(done), 64'd1);
    check("stall.LO", 64'(LO), 64'd9);
    step();
    check("second_start_not_queued", 64'(busy), 64'd0);
    check("mtlo_busy_ignored", 64'(LO), 64'd9);
    lo_we = 1'b1; wdata = 32'h1234;
    step();
    lo_we = 1'b0;
    check("mtlo_idle", 64'(LO), 64'h1234);
    check("mtlo_idle.HI", 64'(HI), 64'd0);

    // Mid-op reset.
    start = 1'b1; op = 2'd3; In1 = $urandom; In2 = $urandom | 32'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    check("midreset.HI", 64'(HI), 64'd0);
    check("midreset.LO", 64'(LO), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) seen_done++;
    end
    check("midreset.no_done", 64'(seen_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
